// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU, debug) in front of a single-port synchronous memory.
// CPU has priority, but debug is guaranteed a slot after MAX_STREAK consecutive CPU wins.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  logic [SW-1:0]         streak_r;
  logic [SW-1:0]         streak_nxt_s;
  logic                  rd_pend_r;
  logic                  rd_owner_r;   // 1 = debug owns the read in flight
  logic                  cpu_win_s;
  logic                  dbg_win_s;
  logic                  mem_en_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  // Grant selection; reset forces both grants low without waiting for a clock.
  always_comb begin
    cpu_win_s = 1'b0;
    dbg_win_s = 1'b0;
    if (rst == 1'b0) begin
      cpu_win_s = 1'b0;
      dbg_win_s = 1'b0;
    end else if (cpu_req && dbg_req) begin
      if (streak_r == STREAK_MAX) begin
        dbg_win_s = 1'b1;
      end else begin
        cpu_win_s = 1'b1;
      end
    end else begin
      cpu_win_s = cpu_req;
      dbg_win_s = dbg_req;
    end
  end

  // Memory command multiplexer driven by the winning requester.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (dbg_win_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = dbg_we;
      mem_addr_s  = dbg_addr;
      mem_wdata_s = dbg_wdata;
    end else if (cpu_win_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = cpu_we;
      mem_addr_s  = cpu_addr;
      mem_wdata_s = cpu_wdata;
    end else begin
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
    end
  end

  // Streak only counts CPU wins that actually held off a waiting debug request.
  always_comb begin
    streak_nxt_s = streak_r;
    if (!dbg_req || dbg_win_s) begin
      streak_nxt_s = '0;
    end else if (cpu_win_s && (streak_r != STREAK_MAX)) begin
      streak_nxt_s = streak_r + STREAK_ONE;
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  // Arbiter state: streak counter and the single outstanding read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_r   <= '0;
      rd_pend_r  <= 1'b0;
      rd_owner_r <= 1'b0;
    end else begin
      streak_r   <= streak_nxt_s;
      rd_pend_r  <= mem_en_s & ~mem_we_s;
      rd_owner_r <= dbg_win_s;
    end
  end

  assign cpu_gnt    = cpu_win_s;
  assign dbg_gnt    = dbg_win_s;
  assign mem_en     = mem_en_s;
  assign mem_we     = mem_we_s;
  assign mem_addr   = mem_addr_s;
  assign mem_wdata  = mem_wdata_s;
  assign cpu_rvalid = rst & rd_pend_r & ~rd_owner_r;
  assign dbg_rvalid = rst & rd_pend_r & rd_owner_r;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Single-port synchronous memory: read data appears the cycle after the command.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's request vector at the falling edge, then let it settle.
  task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                      input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd);
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
  endtask

  initial begin
    logic prev_d;
    logic exp_d;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[4] = 8'hA5;
    mem_rdata = 8'h00;
    rst = 1'b0;

    // Held in reset with both requesting
    step(1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    step(1'b1, 1'b1, 8'h04, 8'h00, 1'b1, 1'b1, 8'h10, 8'h00);
    chk("rst_mem_we2", mem_we, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;

    // CPU read of address 4
    step(1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rd_cpu_gnt", cpu_gnt, 1'b1);
    chk("rd_dbg_gnt", dbg_gnt, 1'b0);
    chk("rd_mem_en", mem_en, 1'b1);
    chk("rd_mem_we", mem_we, 1'b0);
    chk("rd_mem_addr", mem_addr, 8'h04);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rd_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("rd_cpu_rdata", cpu_rdata, 8'hA5);
    chk("rd_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("idle_mem_en", mem_en, 1'b0);

    // Debug write alone, then read it back through the debug port
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h3C);
    chk("wr_dbg_gnt", dbg_gnt, 1'b1);
    chk("wr_cpu_gnt", cpu_gnt, 1'b0);
    chk("wr_mem_en", mem_en, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 8'h3C);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("wr_no_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("wr_no_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("dbgrd_gnt", dbg_gnt, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("dbgrd_rvalid", dbg_rvalid, 1'b1);
    chk("dbgrd_rdata", dbg_rdata, 8'h3C);
    chk("dbgrd_cpu_rvalid", cpu_rvalid, 1'b0);

    // Contention: CPU x4 then DBG, repeating; rvalid tracks previous owner
    prev_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      exp_d = ((k % 5) == 4);
      chk($sformatf("ct%0d_cpu_gnt", k), cpu_gnt, !exp_d);
      chk($sformatf("ct%0d_dbg_gnt", k), dbg_gnt, exp_d);
      chk($sformatf("ct%0d_mem_addr", k), mem_addr, exp_d ? 8'h10 : 8'h01);
      if (k > 0) begin
        chk($sformatf("ct%0d_cpu_rvalid", k), cpu_rvalid, !prev_d);
        chk($sformatf("ct%0d_dbg_rvalid", k), dbg_rvalid, prev_d);
        chk($sformatf("ct%0d_rdata", k), prev_d ? dbg_rdata : cpu_rdata, prev_d ? 8'h3C : 8'h5B);
      end
      prev_d = exp_d;
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("ct_last_dbg_rvalid", dbg_rvalid, 1'b1);
    chk("ct_last_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("ct_last_rdata", dbg_rdata, 8'h3C);

    // Pipelined CPU reads of addresses 0,1,2
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("pl_gnt0", cpu_gnt, 1'b1);
    step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("pl_rvalid0", cpu_rvalid, 1'b1);
    chk("pl_rdata0", cpu_rdata, 8'h5A);
    step(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("pl_rvalid1", cpu_rvalid, 1'b1);
    chk("pl_rdata1", cpu_rdata, 8'h5B);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("pl_rvalid2", cpu_rvalid, 1'b1);
    chk("pl_rdata2", cpu_rdata, 8'h58);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("pl_rvalid_end", cpu_rvalid, 1'b0);

    // Reset mid-read with streak built up to 3 and a CPU read granted
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      chk($sformatf("mr%0d_cpu_gnt", k), cpu_gnt, 1'b1);
    end
    step(1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("mr_read_gnt", cpu_gnt, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mr_rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("mr_rst_dbg_gnt", dbg_gnt, 1'b0);
    chk("mr_rst_mem_en", mem_en, 1'b0);
    chk("mr_rst_cpu_rvalid", cpu_rvalid, 1'b0);
    cpu_we = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("mr_post_cpu_gnt", cpu_gnt, 1'b1);
    chk("mr_post_dbg_gnt", dbg_gnt, 1'b0);
    chk("mr_post_mem_we", mem_we, 1'b1);
    step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("mr_no_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("mr_no_dbg_rvalid", dbg_rvalid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      chk($sformatf("ms%0d_cpu_gnt", k), cpu_gnt, k != 3);
      chk($sformatf("ms%0d_dbg_gnt", k), dbg_gnt, k == 3);
    end
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("ms_end_dbg_rvalid", dbg_rvalid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, data memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-003 The block SHALL have parameter MAX_STREAK, default 4, maximum consecutive CPU grants while a debug request is pending.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1; cpu_we  input  1; cpu_addr  input  ADDR_WIDTH; cpu_wdata  input  DATA_WIDTH: CPU access request.
REQ-007 cpu_gnt  output  1; cpu_rvalid  output  1; cpu_rdata  output  DATA_WIDTH: CPU grant and read return.
REQ-008 dbg_req  input  1; dbg_we  input  1; dbg_addr  input  ADDR_WIDTH; dbg_wdata  input  DATA_WIDTH: debug/host access request.
REQ-009 dbg_gnt  output  1; dbg_rvalid  output  1; dbg_rdata  output  DATA_WIDTH: debug grant and read return.
REQ-010 mem_en  output  1; mem_we  output  1; mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH: single-port synchronous memory command.
REQ-011 mem_rdata  input  DATA_WIDTH: memory read data, valid the cycle after a read command.

Function
REQ-012 Arbitration SHALL be combinational on the current cycle's requests; at most one of cpu_gnt/dbg_gnt high per cycle.
REQ-013 A grant SHALL be issued only to an asserting requester; no request -> both gnt low, mem_en low.
REQ-014 Priority: CPU wins when both request, unless streak counter == MAX_STREAK, then debug wins.
REQ-015 Streak counter: +1 per CPU grant while dbg_req high; cleared on any debug grant or any cycle dbg_req low; saturates at MAX_STREAK.
REQ-016 In the grant cycle mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the granted requester's we/addr/wdata.
REQ-017 Requesters SHALL hold req, we, addr, wdata stable until granted; the block does not register request fields.
REQ-018 Write: completes in the grant cycle; no rvalid generated.
REQ-019 Read: owner registered at grant; exactly one cycle later the owner's rvalid = 1 for one cycle and its rdata = mem_rdata.
REQ-020 Non-owner rvalid SHALL be 0; rdata outputs SHALL pass mem_rdata unconditionally (qualified only by rvalid).
REQ-021 Back-to-back accesses SHALL be accepted every cycle (throughput 1/cycle); a read returning and a new grant in the same cycle are independent.
REQ-022 A requester holding req high after gnt SHALL be treated as a new request (next access).
REQ-023 Registered state: streak counter, read-in-flight flag, read owner; nothing else.

Reset
REQ-024 rst low SHALL immediately clear streak counter, in-flight flag and owner, independent of clk.
REQ-025 During reset cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid SHALL be 0 regardless of requests.
REQ-026 A read granted in the cycle before reset assertion SHALL NOT produce rvalid after reset release.
REQ-027 First arbitration after rst deasserts SHALL use streak = 0.

Verification
REQ-028 Reset: rst=0 with cpu_req=dbg_req=1 -> all gnt, mem_en, rvalid outputs 0.
REQ-029 CPU read: cpu_req=1, we=0, addr=0x04, memory[4]=0xA5 -> cpu_gnt=1 and mem_addr=0x04 that cycle; next cycle cpu_rvalid=1, cpu_rdata=0xA5, dbg_rvalid=0.
REQ-030 Debug write alone: dbg_req=1, we=1, addr=0x10, wdata=0x3C -> dbg_gnt=1, mem_en=1, mem_we=1, mem_wdata=0x3C; no rvalid next cycle.
REQ-031 Contention: both request reads continuously, MAX_STREAK=4 -> grant pattern CPU,CPU,CPU,CPU,DBG repeating; rvalid follows each grant by one cycle to the correct owner.
REQ-032 Pipelined reads: CPU reads addr 0,1,2 on consecutive cycles -> rvalid high three consecutive cycles with data of addr 0,1,2 in order.
REQ-033 Reset mid-read: CPU read granted, rst pulsed low before next edge -> cpu_rvalid stays 0 after release; streak restarts from 0.
